// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the SDRAM burst arbiter.
package sdram_arb_pkg;

    localparam int ADDR_WD_DEF    = 14;
    localparam int BURST_LEN_DEF  = 256;
    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BURST = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_CAM   = 2'd1,
        SRC_VGA   = 2'd2,
        SRC_SOBEL = 2'd3
    } arb_src_t;

    // VGA is the only read requester; camera and Sobel both write.
    function automatic logic src_is_read(arb_src_t src);
        return src == SRC_VGA;
    endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// Requester, controller and status signals of the SDRAM burst arbiter.
interface sdram_burst_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WD = ADDR_WD_DEF
);
    logic               cam_req;
    logic [ADDR_WD-1:0] cam_addr;
    logic               vga_req;
    logic [ADDR_WD-1:0] vga_addr;
    logic               sobel_req;
    logic [ADDR_WD-1:0] sobel_addr;
    logic               cam_gnt;
    logic               vga_gnt;
    logic               sobel_gnt;
    logic               cam_done;
    logic               vga_done;
    logic               sobel_done;
    logic               ready;
    logic               fpga_data_valid;
    logic               sd_data_valid;
    logic               rw;
    logic               rw_en;
    logic [ADDR_WD-1:0] sd_addr;
    logic               busy;
    logic [1:0]         cur_src;

    modport master (
        input  cam_req, cam_addr, vga_req, vga_addr, sobel_req, sobel_addr,
        input  ready, fpga_data_valid, sd_data_valid,
        output cam_gnt, vga_gnt, sobel_gnt, cam_done, vga_done, sobel_done,
        output rw, rw_en, sd_addr, busy, cur_src
    );

    modport slave (
        output cam_req, cam_addr, vga_req, vga_addr, sobel_req, sobel_addr,
        output ready, fpga_data_valid, sd_data_valid,
        input  cam_gnt, vga_gnt, sobel_gnt, cam_done, vga_done, sobel_done,
        input  rw, rw_en, sd_addr, busy, cur_src
    );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: promoted requesters first, then cam > vga > sobel.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic     i_cam_req,
    input  logic     i_vga_req,
    input  logic     i_sobel_req,
    input  logic     i_vga_promo,
    input  logic     i_sobel_promo,
    output arb_src_t o_winner
);

    always_comb begin
        o_winner = SRC_NONE;
        if (i_vga_req && i_vga_promo) begin
            o_winner = SRC_VGA;
        end else if (i_sobel_req && i_sobel_promo) begin
            o_winner = SRC_SOBEL;
        end else if (i_cam_req) begin
            o_winner = SRC_CAM;
        end else if (i_vga_req) begin
            o_winner = SRC_VGA;
        end else if (i_sobel_req) begin
            o_winner = SRC_SOBEL;
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Burst arbiter for the shared SDRAM command port (camera write, VGA read, Sobel write).
// Define SDRAM_ARB_STARVE_EN to compile in the vga/sobel loss counters and promotion.
//
// state    | meaning
// ST_IDLE  | no burst in flight; arbitrate when ready and any request is high
// ST_ISSUE | winner latched; rw_en driven until the controller is ready
// ST_BURST | counting data beats of the granted direction
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WD    = ADDR_WD_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  sdram_clk,
    input  logic                  rst_ni,
    sdram_burst_arbiter_if.master bus
);

    localparam int                CNT_WD    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_WD-1:0] LAST_BEAT = CNT_WD'(BURST_LEN - 1);

    arb_state_t         r_state;
    arb_src_t           r_src;
    logic [CNT_WD-1:0]  r_beat;
    logic               r_rw;
    logic               r_rw_en;
    logic               r_busy;
    logic [ADDR_WD-1:0] r_sd_addr;
    logic               r_cam_gnt;
    logic               r_vga_gnt;
    logic               r_sobel_gnt;
    logic               r_cam_done;
    logic               r_vga_done;
    logic               r_sobel_done;

    arb_src_t           w_winner;
    logic               w_arb_now;
    logic               w_beat;
    logic               w_vga_promo;
    logic               w_sobel_promo;
    logic [ADDR_WD-1:0] w_sel_addr;

    sdram_arb_pick u_pick (
        .i_cam_req     (bus.cam_req),
        .i_vga_req     (bus.vga_req),
        .i_sobel_req   (bus.sobel_req),
        .i_vga_promo   (w_vga_promo),
        .i_sobel_promo (w_sobel_promo),
        .o_winner      (w_winner)
    );

    assign w_arb_now = (r_state == ST_IDLE) && bus.ready && (w_winner != SRC_NONE);
    assign w_beat    = r_rw ? bus.sd_data_valid : bus.fpga_data_valid;

    always_comb begin
        w_sel_addr = '0;
        case (w_winner)
            SRC_CAM:   w_sel_addr = bus.cam_addr;
            SRC_VGA:   w_sel_addr = bus.vga_addr;
            SRC_SOBEL: w_sel_addr = bus.sobel_addr;
            default:   w_sel_addr = '0;
        endcase
    end

`ifdef SDRAM_ARB_STARVE_EN
    localparam int                 LOSS_WD  = $clog2(STARVE_MAX + 1);
    localparam logic [LOSS_WD-1:0] LOSS_MAX = LOSS_WD'(STARVE_MAX);

    logic [LOSS_WD-1:0] r_vga_loss;
    logic [LOSS_WD-1:0] r_sobel_loss;

    // Losses only count at an actual arbitration, and saturate at the promotion level.
    always_ff @(posedge sdram_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vga_loss   <= '0;
            r_sobel_loss <= '0;
        end else if (w_arb_now) begin
            if (w_winner == SRC_VGA) begin
                r_vga_loss <= '0;
            end else if (bus.vga_req && (r_vga_loss != LOSS_MAX)) begin
                r_vga_loss <= r_vga_loss + 1'b1;
            end
            if (w_winner == SRC_SOBEL) begin
                r_sobel_loss <= '0;
            end else if (bus.sobel_req && (r_sobel_loss != LOSS_MAX)) begin
                r_sobel_loss <= r_sobel_loss + 1'b1;
            end
        end
    end

    assign w_vga_promo   = (r_vga_loss == LOSS_MAX);
    assign w_sobel_promo = (r_sobel_loss == LOSS_MAX);
`else
    assign w_vga_promo   = 1'b0;
    assign w_sobel_promo = 1'b0;
`endif

    always_ff @(posedge sdram_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_src        <= SRC_NONE;
            r_beat       <= '0;
            r_rw         <= 1'b0;
            r_rw_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_sd_addr    <= '0;
            r_cam_gnt    <= 1'b0;
            r_vga_gnt    <= 1'b0;
            r_sobel_gnt  <= 1'b0;
            r_cam_done   <= 1'b0;
            r_vga_done   <= 1'b0;
            r_sobel_done <= 1'b0;
        end else begin
            r_cam_gnt    <= 1'b0;
            r_vga_gnt    <= 1'b0;
            r_sobel_gnt  <= 1'b0;
            r_cam_done   <= 1'b0;
            r_vga_done   <= 1'b0;
            r_sobel_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_now) begin
                        r_state   <= ST_ISSUE;
                        r_src     <= w_winner;
                        r_rw      <= src_is_read(w_winner);
                        r_sd_addr <= w_sel_addr;
                        r_busy    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // rw_en stays up while ready is low; the grant marks the accepting cycle.
                    r_rw_en <= 1'b1;
                    if (bus.ready) begin
                        r_state     <= ST_BURST;
                        r_beat      <= '0;
                        r_cam_gnt   <= (r_src == SRC_CAM);
                        r_vga_gnt   <= (r_src == SRC_VGA);
                        r_sobel_gnt <= (r_src == SRC_SOBEL);
                    end
                end
                ST_BURST: begin
                    r_rw_en <= 1'b0;
                    if (w_beat) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_src        <= SRC_NONE;
                            r_cam_done   <= (r_src == SRC_CAM);
                            r_vga_done   <= (r_src == SRC_VGA);
                            r_sobel_done <= (r_src == SRC_SOBEL);
                        end else if (r_beat != '1) begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cam_gnt    = r_cam_gnt;
    assign bus.vga_gnt    = r_vga_gnt;
    assign bus.sobel_gnt  = r_sobel_gnt;
    assign bus.cam_done   = r_cam_done;
    assign bus.vga_done   = r_vga_done;
    assign bus.sobel_done = r_sobel_done;
    assign bus.rw         = r_rw;
    assign bus.rw_en      = r_rw_en;
    assign bus.sd_addr    = r_sd_addr;
    assign bus.busy       = r_busy;
    assign bus.cur_src    = r_src;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: a burst-level reference model checked every cycle,
// plus hand-computed latency/count expectations. Honours SDRAM_ARB_STARVE_EN like the design.
module tb_sdram_burst_arbiter;

    localparam int AW   = 14;
    localparam int BL   = 256;
    localparam int SMAX = 8;

    logic sdram_clk = 1'b0;
    logic rst_ni;

    always #5 sdram_clk = ~sdram_clk;

    sdram_burst_arbiter_if #(.ADDR_WD(AW)) bus ();

    sdram_burst_arbiter #(
        .ADDR_WD    (AW),
        .BURST_LEN  (BL),
        .STARVE_MAX (SMAX)
    ) dut (
        .sdram_clk (sdram_clk),
        .rst_ni    (rst_ni),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_rw_en  = 0;
    int n_gnt  [4] = '{0, 0, 0, 0};
    int n_done [4] = '{0, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one command per burst, then BL beats of the source's direction.
    int          m_phase;
    int          m_src;
    int          m_win;
    int          m_left;
    int          m_loss [4];
    bit [3:0]    e_gnt;
    bit [3:0]    e_done;
    bit          e_rw;
    bit          e_rw_en;
    bit          e_busy;
    bit [AW-1:0] e_addr;
    bit [1:0]    e_src;

    function automatic int pick_src(bit c, bit v, bit s, int lv, int ls);
        bit promo_on = 1'b0;
`ifdef SDRAM_ARB_STARVE_EN
        promo_on = 1'b1;
`endif
        if (promo_on && v && lv >= SMAX) return 2;
        if (promo_on && s && ls >= SMAX) return 3;
        if (c) return 1;
        if (v) return 2;
        if (s) return 3;
        return 0;
    endfunction

    function automatic bit req_of(int src);
        case (src)
            1: return bus.cam_req;
            2: return bus.vga_req;
            3: return bus.sobel_req;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [AW-1:0] addr_of(int src);
        case (src)
            1: return bus.cam_addr;
            2: return bus.vga_addr;
            3: return bus.sobel_addr;
            default: return '0;
        endcase
    endfunction

    always @(posedge sdram_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase = 0;
            m_src   = 0;
            m_left  = 0;
            foreach (m_loss[i]) m_loss[i] = 0;
            e_gnt   = '0;
            e_done  = '0;
            e_rw    = 1'b0;
            e_rw_en = 1'b0;
            e_busy  = 1'b0;
            e_addr  = '0;
            e_src   = '0;
        end else begin
            e_gnt  = '0;
            e_done = '0;
            if (m_phase == 0) begin
                if (bus.ready && (bus.cam_req || bus.vga_req || bus.sobel_req)) begin
                    m_win = pick_src(bus.cam_req, bus.vga_req, bus.sobel_req, m_loss[2], m_loss[3]);
                    for (int r = 2; r <= 3; r++) begin
                        if (r == m_win) m_loss[r] = 0;
                        else if (req_of(r)) m_loss[r]++;
                    end
                    m_src   = m_win;
                    e_rw    = (m_win == 2);
                    e_addr  = addr_of(m_win);
                    e_busy  = 1'b1;
                    e_src   = 2'(m_win);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                e_rw_en = 1'b1;
                if (bus.ready) begin
                    e_gnt[m_src] = 1'b1;
                    m_left       = BL;
                    m_phase      = 2;
                end
            end else begin
                e_rw_en = 1'b0;
                if ((m_src == 2) ? bus.sd_data_valid : bus.fpga_data_valid) begin
                    m_left--;
                    if (m_left == 0) begin
                        e_done[m_src] = 1'b1;
                        e_busy        = 1'b0;
                        e_src         = '0;
                        m_phase       = 0;
                    end
                end
            end
        end
    end

    wire [24:0] w_act = {bus.cam_gnt, bus.vga_gnt, bus.sobel_gnt,
                         bus.cam_done, bus.vga_done, bus.sobel_done,
                         bus.rw, bus.rw_en, bus.sd_addr, bus.busy, bus.cur_src};
    wire [24:0] w_exp = {e_gnt[1], e_gnt[2], e_gnt[3],
                         e_done[1], e_done[2], e_done[3],
                         e_rw, e_rw_en, e_addr, e_busy, e_src};

    always @(posedge sdram_clk) begin
        #2;
        check("cycle_model", 32'(w_act), 32'(w_exp));
        if (bus.rw_en)      n_rw_en++;
        if (bus.cam_gnt)    n_gnt[1]++;
        if (bus.vga_gnt)    n_gnt[2]++;
        if (bus.sobel_gnt)  n_gnt[3]++;
        if (bus.cam_done)   n_done[1]++;
        if (bus.vga_done)   n_done[2]++;
        if (bus.sobel_done) n_done[3]++;
    end

    task automatic wait_cmd(output int lat);
        lat = 0;
        do begin
            @(negedge sdram_clk);
            lat++;
        end while (!(bus.cam_gnt || bus.vga_gnt || bus.sobel_gnt) && lat < 600);
        n_checks++;
        if (!(bus.cam_gnt || bus.vga_gnt || bus.sobel_gnt)) begin
            n_fail++;
            $display("FAIL cmd_timeout: no grant seen after %0d cycles, required one", lat);
        end
    endtask

    task automatic beats(input bit rd, input int n);
        for (int i = 0; i < n; i++) begin
            if (rd) bus.sd_data_valid = 1'b1;
            else    bus.fpga_data_valid = 1'b1;
            @(negedge sdram_clk);
        end
        bus.sd_data_valid   = 1'b0;
        bus.fpga_data_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0, r0, g0, n_cam;
        bit got_sobel;

        rst_ni              = 1'b0;
        bus.cam_req         = 1'b0;
        bus.vga_req         = 1'b0;
        bus.sobel_req       = 1'b0;
        bus.cam_addr        = '0;
        bus.vga_addr        = '0;
        bus.sobel_addr      = '0;
        bus.ready           = 1'b1;
        bus.fpga_data_valid = 1'b0;
        bus.sd_data_valid   = 1'b0;
        repeat (3) @(negedge sdram_clk);
        rst_ni = 1'b1;
        @(negedge sdram_clk);
        check("reset_outputs", 32'(w_act), 32'h0);

        // single camera burst
        bus.cam_addr = 14'd5;
        bus.cam_req  = 1'b1;
        r0 = n_rw_en;
        wait_cmd(lat);
        check("t1_latency", lat, 2);
        check("t1_rw", bus.rw, 0);
        check("t1_addr", bus.sd_addr, 5);
        check("t1_cam_gnt", bus.cam_gnt, 1);
        bus.cam_req = 1'b0;
        d0 = n_done[1];
        beats(0, BL);
        check("t1_cam_done", bus.cam_done, 1);
        check("t1_busy", bus.busy, 0);
        check("t1_done_count", n_done[1] - d0, 1);
        check("t1_rw_en_cycles", n_rw_en - r0, 1);

        // cam beats vga; vga follows with a read burst, ignoring write beats
        bus.cam_addr = 14'h0123;
        bus.vga_addr = 14'h02A5;
        bus.cam_req  = 1'b1;
        bus.vga_req  = 1'b1;
        wait_cmd(lat);
        check("t2_first_src", bus.cur_src, 1);
        check("t2_cam_gnt", bus.cam_gnt, 1);
        bus.cam_req = 1'b0;
        beats(0, BL);
        wait_cmd(lat);
        check("t2_done_to_cmd", lat, 2);
        check("t2_vga_gnt", bus.vga_gnt, 1);
        check("t2_rw", bus.rw, 1);
        check("t2_addr", bus.sd_addr, 14'h02A5);
        bus.vga_req = 1'b0;
        d0 = n_done[2];
        bus.fpga_data_valid = 1'b1;
        beats(1, BL);
        check("t2_vga_done", n_done[2] - d0, 1);

        // ready low for 5 cycles while the command is pending
        bus.sobel_addr = 14'h3FFF;
        bus.sobel_req  = 1'b1;
        r0 = n_rw_en;
        g0 = n_gnt[3];
        @(negedge sdram_clk);
        bus.ready = 1'b0;
        repeat (5) @(negedge sdram_clk);
        bus.ready = 1'b1;
        wait_cmd(lat);
        check("t3_gnt_after_ready", lat, 1);
        check("t3_rw_en_cycles", n_rw_en - r0, 6);
        check("t3_gnt_count", n_gnt[3] - g0, 1);
        check("t3_addr", bus.sd_addr, 14'h3FFF);
        bus.sobel_req = 1'b0;
        beats(0, BL);
        check("t3_sobel_done", bus.sobel_done, 1);

        // reset at beat 100 of a vga burst, then a fresh vga burst
        bus.vga_addr = 14'h0100;
        bus.vga_req  = 1'b1;
        wait_cmd(lat);
        bus.vga_req = 1'b0;
        d0 = n_done[2];
        beats(1, 100);
        rst_ni = 1'b0;
        @(posedge sdram_clk);
        #2;
        check("t4_reset_outputs", 32'(w_act), 32'h0);
        repeat (2) @(negedge sdram_clk);
        rst_ni = 1'b1;
        check("t4_no_done", n_done[2] - d0, 0);
        bus.vga_addr = 14'h0101;
        bus.vga_req  = 1'b1;
        wait_cmd(lat);
        check("t4_latency", lat, 2);
        check("t4_addr", bus.sd_addr, 14'h0101);
        bus.vga_req = 1'b0;
        beats(1, BL - 1);
        check("t4_not_done_early", n_done[2] - d0, 0);
        beats(1, 1);
        check("t4_done_on_last", bus.vga_done, 1);

        // 300 write beats: done after 256, extras ignored in IDLE
        bus.cam_addr = 14'd9;
        bus.cam_req  = 1'b1;
        wait_cmd(lat);
        bus.cam_req = 1'b0;
        d0 = n_done[1];
        r0 = n_rw_en;
        beats(0, 300);
        check("t5_single_done", n_done[1] - d0, 1);
        check("t5_no_new_cmd", n_rw_en - r0, 0);
        check("t5_idle_busy", bus.busy, 0);

        // cam and sobel held: promotion after STARVE_MAX losses, or never without it
        bus.cam_addr   = 14'd20;
        bus.sobel_addr = 14'd30;
        bus.cam_req    = 1'b1;
        bus.sobel_req  = 1'b1;
        n_cam     = 0;
        got_sobel = 1'b0;
        for (int b = 0; b < 13 && !got_sobel; b++) begin
            wait_cmd(lat);
            if (bus.sobel_gnt) got_sobel = 1'b1;
            else               n_cam++;
            if (got_sobel || b == 12) begin
                bus.cam_req   = 1'b0;
                bus.sobel_req = 1'b0;
            end
            beats(0, BL);
        end
`ifdef SDRAM_ARB_STARVE_EN
        check("t6_cam_bursts", n_cam, 8);
        check("t6_sobel_granted", got_sobel, 1);
`else
        check("t6_cam_bursts", n_cam, 13);
        check("t6_sobel_granted", got_sobel, 0);
`endif
        repeat (3) @(negedge sdram_clk);
        check("t6_final_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
